// File: rtl/ifetch_unit_if.sv
// ============================================================================
// Module      : ifetch_unit_if
// Description : Control-unit handshake and instruction-bus signals of the fetch stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_unit_if;
  logic        ifu_valid;
  logic        ifu_finish;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        ifu_err;
  logic        pc_we;
  logic [63:0] pc_next;
  logic        ibus_req;
  logic [63:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_rdata;

  // master = fetch unit, slave = control unit plus memory side
  modport master (
    input  ifu_valid, pc_we, pc_next, ibus_addr_ok, ibus_data_ok, ibus_rdata,
    output ifu_finish, instr, pc, ifu_err, ibus_req, ibus_addr
  );

  modport slave (
    output ifu_valid, pc_we, pc_next, ibus_addr_ok, ibus_data_ok, ibus_rdata,
    input  ifu_finish, instr, pc, ifu_err, ibus_req, ibus_addr
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Multi-cycle instruction fetch with PC ownership, redirect and bus timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
  parameter logic [63:0] PC_RESET    = 64'h8000_0000,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  localparam logic [1:0]  c_IDLE = 2'd0;
  localparam logic [1:0]  c_REQ  = 2'd1;
  localparam logic [1:0]  c_WAIT = 2'd2;
  localparam logic [1:0]  c_DONE = 2'd3;
  localparam logic [31:0] c_NOP  = 32'h0000_0013;

  // Counter only needs to reach BUS_TIMEOUT-1; the cycle after that is the timeout.
  localparam int unsigned      c_CW       = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(BUS_TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [63:0]     r_npc;
  logic [63:0]     r_fetch_addr;
  logic [c_CW-1:0] r_cnt;
  logic            r_redir_pend;
  logic [63:0]     r_redir_pc;
  logic [31:0]     r_instr;
  logic [63:0]     r_pc;
  logic            r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_npc        <= PC_RESET;
      r_fetch_addr <= 64'd0;
      r_cnt        <= '0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 64'd0;
      r_instr      <= c_NOP;
      r_pc         <= PC_RESET;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.ifu_valid) begin
            r_fetch_addr <= r_npc;
            if (r_npc[1:0] == 2'b00) begin
              r_state <= c_REQ;
            end else begin
              r_state <= c_DONE;
              r_instr <= c_NOP;
              r_pc    <= r_npc;
              r_err   <= 1'b1;
            end
            // The fetch just started keeps the old npc; the redirect waits for DONE.
            if (bus.pc_we) begin
              r_redir_pend <= 1'b1;
              r_redir_pc   <= bus.pc_next;
            end
          end else if (bus.pc_we) begin
            r_npc <= bus.pc_next;
          end
        end
        c_REQ: begin
          if (bus.ibus_addr_ok) begin
            if (bus.ibus_data_ok) begin
              r_state <= c_DONE;
              r_instr <= bus.ibus_rdata;
              r_pc    <= r_fetch_addr;
              r_err   <= 1'b0;
            end else begin
              r_state <= c_WAIT;
              r_cnt   <= '0;
            end
          end
        end
        c_WAIT: begin
          if (bus.ibus_data_ok) begin
            r_state <= c_DONE;
            r_instr <= bus.ibus_rdata;
            r_pc    <= r_fetch_addr;
            r_err   <= 1'b0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= c_DONE;
            r_instr <= c_NOP;
            r_pc    <= r_fetch_addr;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE: begin
          r_state      <= c_IDLE;
          r_redir_pend <= 1'b0;
          if (bus.pc_we) begin
            r_npc <= bus.pc_next;
          end else if (r_redir_pend) begin
            r_npc <= r_redir_pc;
          end else begin
            r_npc <= r_fetch_addr + 64'd4;
          end
        end
        default: r_state <= c_IDLE;
      endcase

      if (bus.pc_we && (r_state == c_REQ || r_state == c_WAIT)) begin
        r_redir_pend <= 1'b1;
        r_redir_pc   <= bus.pc_next;
      end
    end
  end

  assign bus.ifu_finish = (r_state == c_DONE);
  assign bus.instr      = r_instr;
  assign bus.pc         = r_pc;
  assign bus.ifu_err    = r_err;
  assign bus.ibus_req   = (r_state == c_REQ);
  assign bus.ibus_addr  = (r_state == c_REQ) ? r_fetch_addr : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed vector table plus hand sequences for ifetch_unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .PC_RESET    (64'h8000_0000),
    .BUS_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [63:0] pnext;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_fin;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_err;
  } vec_t;

  localparam int c_NV = 26;
  vec_t vt [c_NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [63:0] pn,
                       input logic aok, input logic dok, input logic [31:0] rd);
    bus.ifu_valid    = v;
    bus.pc_we        = we;
    bus.pc_next      = pn;
    bus.ibus_addr_ok = aok;
    bus.ibus_data_ok = dok;
    bus.ibus_rdata   = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 0, 64'd0, 0, 0, 32'd0);

    // Per cycle: expected outputs seen this cycle, then the inputs driven for it.
    //         valid we pnext                aok dok rdata         req addr                 fin instr          pc                   err
    vt[0]  = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0000, 0};
    vt[1]  = '{1, 0, 64'd0,                1, 1, 32'h0050_0093, 1, 64'h8000_0000,        0, 32'h0000_0013, 64'h8000_0000, 0};
    vt[2]  = '{0, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h0050_0093, 64'h8000_0000, 0};
    vt[3]  = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0050_0093, 64'h8000_0000, 0};
    vt[4]  = '{1, 0, 64'd0,                1, 0, 32'd0,         1, 64'h8000_0004,        0, 32'h0050_0093, 64'h8000_0000, 0};
    vt[5]  = '{1, 1, 64'h8000_0100,        0, 0, 32'd0,         0, 64'd0,                0, 32'h0050_0093, 64'h8000_0000, 0};
    vt[6]  = '{1, 0, 64'd0,                0, 1, 32'h00a0_0113, 0, 64'd0,                0, 32'h0050_0093, 64'h8000_0000, 0};
    vt[7]  = '{0, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h00a0_0113, 64'h8000_0004, 0};
    vt[8]  = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h00a0_0113, 64'h8000_0004, 0};
    vt[9]  = '{1, 1, 64'h8000_0102,        1, 1, 32'h00f0_0193, 1, 64'h8000_0100,        0, 32'h00a0_0113, 64'h8000_0004, 0};
    vt[10] = '{0, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h00f0_0193, 64'h8000_0100, 0};
    vt[11] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h00f0_0193, 64'h8000_0100, 0};
    vt[12] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h0000_0013, 64'h8000_0102, 1};
    vt[13] = '{1, 1, 64'h8000_0200,        0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0102, 1};
    vt[14] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h0000_0013, 64'h8000_0106, 1};
    vt[15] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[16] = '{1, 0, 64'd0,                0, 0, 32'd0,         1, 64'h8000_0200,        0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[17] = '{1, 0, 64'd0,                0, 0, 32'd0,         1, 64'h8000_0200,        0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[18] = '{1, 0, 64'd0,                0, 0, 32'd0,         1, 64'h8000_0200,        0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[19] = '{1, 0, 64'd0,                1, 0, 32'd0,         1, 64'h8000_0200,        0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[20] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[21] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[22] = '{1, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[23] = '{1, 0, 64'd0,                0, 1, 32'h1234_5678, 0, 64'd0,                0, 32'h0000_0013, 64'h8000_0106, 1};
    vt[24] = '{0, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                1, 32'h1234_5678, 64'h8000_0200, 0};
    vt[25] = '{0, 0, 64'd0,                0, 0, 32'd0,         0, 64'd0,                0, 32'h1234_5678, 64'h8000_0200, 0};

    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < c_NV; i++) begin
      chk($sformatf("v%0d_req", i),   {63'd0, bus.ibus_req},   {63'd0, vt[i].e_req});
      chk($sformatf("v%0d_addr", i),  bus.ibus_addr,           vt[i].e_addr);
      chk($sformatf("v%0d_fin", i),   {63'd0, bus.ifu_finish}, {63'd0, vt[i].e_fin});
      chk($sformatf("v%0d_instr", i), {32'd0, bus.instr},      {32'd0, vt[i].e_instr});
      chk($sformatf("v%0d_pc", i),    bus.pc,                  vt[i].e_pc);
      chk($sformatf("v%0d_err", i),   {63'd0, bus.ifu_err},    {63'd0, vt[i].e_err});
      drive(vt[i].valid, vt[i].we, vt[i].pnext, vt[i].aok, vt[i].dok, vt[i].rdata);
      tick();
    end

    // Bus timeout after four silent WAIT cycles, then a clean fetch
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("to_req_addr", bus.ibus_addr, 64'h8000_0204);
    drive(1, 0, 64'd0, 1, 0, 32'd0);
    tick();
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    n = 0;
    while (!bus.ifu_finish && n < 20) begin
      tick();
      n++;
    end
    chk("to_wait_cycles", 64'(n), 64'd4);
    chk("to_err", {63'd0, bus.ifu_err}, 64'd1);
    chk("to_instr", {32'd0, bus.instr}, 64'h0000_0013);
    chk("to_pc", bus.pc, 64'h8000_0204);
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    tick();
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("post_to_addr", bus.ibus_addr, 64'h8000_0208);
    drive(1, 0, 64'd0, 1, 1, 32'h0010_8093);
    tick();
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    chk("post_to_fin", {63'd0, bus.ifu_finish}, 64'd1);
    chk("post_to_err", {63'd0, bus.ifu_err}, 64'd0);
    chk("post_to_instr", {32'd0, bus.instr}, 64'h0010_8093);
    tick();

    // Reset during WAIT, stale data_ok afterwards must be ignored
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("rw_addr", bus.ibus_addr, 64'h8000_020C);
    drive(1, 0, 64'd0, 1, 0, 32'd0);
    tick();
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 64'd0, 0, 1, 32'hDEAD_BEEF);
    chk("rw_fin0", {63'd0, bus.ifu_finish}, 64'd0);
    chk("rw_req0", {63'd0, bus.ibus_req}, 64'd0);
    chk("rw_pc", bus.pc, 64'h8000_0000);
    chk("rw_instr", {32'd0, bus.instr}, 64'h0000_0013);
    tick();
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    chk("rw_fin1", {63'd0, bus.ifu_finish}, 64'd0);
    tick();
    chk("rw_fin2", {63'd0, bus.ifu_finish}, 64'd0);
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("rw_refetch_addr", bus.ibus_addr, 64'h8000_0000);
    drive(1, 0, 64'd0, 1, 1, 32'h0000_0073);
    tick();
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    chk("rw_refetch_fin", {63'd0, bus.ifu_finish}, 64'd1);
    chk("rw_refetch_pc", bus.pc, 64'h8000_0000);
    tick();

    // IDLE redirect to the top of the address space, then +4 wraps to zero
    drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'd0);
    tick();
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("wrap_addr", bus.ibus_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 0, 64'd0, 1, 1, 32'h0020_0113);
    tick();
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    chk("wrap_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1, 0, 64'd0, 0, 0, 32'd0);
    tick();
    chk("wrap_next_req", {63'd0, bus.ibus_req}, 64'd1);
    chk("wrap_next_addr", bus.ibus_addr, 64'd0);
    drive(0, 0, 64'd0, 1, 1, 32'd0);
    tick();
    drive(0, 0, 64'd0, 0, 0, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
